// File: rtl/vga_timing_gen_if.sv
// Raster interface of the VGA timing generator.
// The master side (the timing generator) drives the pixel counters, the
// pixel-rate strobe, the pipeline-aligned sync/enable signals and the
// frame markers. The slave side (the drawers and the monitor) samples them.
interface vga_timing_gen_if;

  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        pixTick;
  logic        hsyncN;
  logic        vsyncN;
  logic        active;
  logic        startOfFrame;
  logic [7:0]  frameCnt;

  modport master (
    output pixelX,
    output pixelY,
    output pixTick,
    output hsyncN,
    output vsyncN,
    output active,
    output startOfFrame,
    output frameCnt
  );

  modport slave (
    input pixelX,
    input pixelY,
    input pixTick,
    input hsyncN,
    input vsyncN,
    input active,
    input startOfFrame,
    input frameCnt
  );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// An integer clock divider produces a one-clock pixel strobe. Horizontal and
// vertical counters advance on that strobe. Sync and display-enable signals
// are decoded from the counters, then delayed PIPE_DLY clocks so that they
// line up with the registered RGB produced downstream.
// Optional build macro VGA_FRAME_COUNTER_EN adds an 8-bit frame counter.
// Without that macro, frameCnt is tied to zero.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 1
) (
  input  logic              clk,
  input  logic              resetN,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);

  // Raw sync/enable are packed as {hs, vs, act}.
  // While idle the sync lines are high and the enable is low.
  localparam logic [2:0] RAW_IDLE = 3'b110;

  // The counters are 11 bits wide, so larger rasters cannot be represented.
  // The other parameter ranges are also rejected here at elaboration.
  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2047");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be within 0..7");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [10:0]      pixel_x;
  logic [10:0]      pixel_y;
  logic             tick;
  logic             line_end;
  logic             frame_end;
  logic             sof_q;
  logic             hs_raw;
  logic             vs_raw;
  logic             act_raw;
  logic [2:0]       raw_bits;
  logic [2:0]       dly_out;

  assign tick      = (div_cnt == DIV_LAST);
  assign line_end  = (pixel_x == X_LAST);
  assign frame_end = tick && line_end && (pixel_y == Y_LAST);

  // Pixel-rate divider: count 0..CLK_DIV-1, then wrap.
  // The tick is high on the last count.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster counters: advance one pixel per tick, and wrap at line and frame ends.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (tick) begin
      if (line_end) begin
        pixel_x <= '0;
        if (pixel_y == Y_LAST) begin
          pixel_y <= '0;
        end else begin
          pixel_y <= pixel_y + 11'd1;
        end
      end else begin
        pixel_x <= pixel_x + 11'd1;
      end
    end
  end

  // Frame-start marker: registered so that it coincides with the first clock at (0,0).
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sof_q <= 1'b0;
    end else begin
      sof_q <= frame_end;
    end
  end

  // Undelayed sync and enable decode from the current counter values.
  always_comb begin
    hs_raw  = !((pixel_x >= HS_START) && (pixel_x < HS_END));
    vs_raw  = !((pixel_y >= VS_START) && (pixel_y < VS_END));
    act_raw = (pixel_x < X_ACT) && (pixel_y < Y_ACT);
  end

  assign raw_bits = {hs_raw, vs_raw, act_raw};

  if (PIPE_DLY == 0) begin : g_no_dly
    assign dly_out = raw_bits;
  end else begin : g_dly
    logic [2:0] dly [PIPE_DLY];

    // Alignment shift register: on reset it is filled with idle values,
    // so no partial sync pulse can leak out after a reset.
    always_ff @(posedge clk) begin
      if (!resetN) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          dly[i] <= RAW_IDLE;
        end
      end else begin
        dly[0] <= raw_bits;
        for (int i = 1; i < PIPE_DLY; i++) begin
          dly[i] <= dly[i-1];
        end
      end
    end

    assign dly_out = dly[PIPE_DLY-1];
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_cnt;

  // Frame counter: increments on the same edge that wraps the raster to (0,0).
  always_ff @(posedge clk) begin
    if (!resetN) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign vga.frameCnt = frame_cnt;
`else
  assign vga.frameCnt = 8'h00;
`endif

  assign vga.pixelX       = pixel_x;
  assign vga.pixelY       = pixel_y;
  assign vga.pixTick      = tick;
  assign vga.hsyncN       = dly_out[2];
  assign vga.vsyncN       = dly_out[1];
  assign vga.active       = dly_out[0];
  assign vga.startOfFrame = sof_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream pixel-scan stage of the VGA path: generates the raster counters `pixelX`/`pixelY` consumed by the background and object drawers, plus the hsync, vsync and display-enable signals.
- Sync and enable outputs are delayed to line up with the registered RGB produced one clock later by the drawers.
- Runs on the system clock; a pixel-rate tick is derived internally by an integer divider.

Parameters:
- CLK_DIV, 2, system clocks per pixel (≥1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DLY, 1, clock delay applied to hsyncN/vsyncN/active (0..7)

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- pixelX  out  11  horizontal counter, 0..H_TOTAL-1
- pixelY  out  11  vertical counter, 0..V_TOTAL-1
- pixTick  out  1  one-clk strobe; counters advance on the next edge
- hsyncN  out  1  horizontal sync, active low, delayed PIPE_DLY
- vsyncN  out  1  vertical sync, active low, delayed PIPE_DLY
- active  out  1  visible-region flag, delayed PIPE_DLY
- startOfFrame  out  1  one-clk pulse on wrap to (0,0)
- frameCnt  out  8  frame counter (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; reset `resetN` is synchronous and active-low. All state is sampled on the rising edge of clk.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (resetN=0 at an edge):
  - divCnt, pixelX, pixelY, frameCnt cleared to 0.
  - hsyncN=1, vsyncN=1, active=0, startOfFrame=0, pixTick=0.
  - Delay line filled with the inactive values (1,1,0).
  - Reset mid-line or mid-frame restarts at (0,0) with no partial sync pulse emitted.
- Divider:
  - divCnt counts 0..CLK_DIV-1 and wraps.
  - pixTick=1 while divCnt==CLK_DIV-1; CLK_DIV=1 gives pixTick constantly 1 out of reset.
- Counters: on an edge with pixTick=1, pixelX increments.
  - At H_TOTAL-1, pixelX wraps to 0 and pixelY increments.
  - At V_TOTAL-1 with pixelX wrapping, pixelY wraps to 0.
  - Counters are held between ticks.
- Raw (undelayed) decode from the current counters:
  - hs_raw=0 iff H_ACTIVE+H_FP ≤ pixelX < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw=0 iff V_ACTIVE+V_FP ≤ pixelY < V_ACTIVE+V_FP+V_SYNC (490..491).
  - act_raw=1 iff pixelX<H_ACTIVE and pixelY<V_ACTIVE.
- Delay: hsyncN/vsyncN/active equal the raw values from PIPE_DLY clocks earlier, via a shift register. PIPE_DLY=0 outputs raw decode directly.
- startOfFrame:
  - Registered; high exactly one clk, in the first clock at which pixelY==0 and pixelX==0 following a frame wrap.
  - Not asserted on the first frame after reset.
  - Not delayed by PIPE_DLY.
- Counter width: 11 bits; parameter sets with H_TOTAL or V_TOTAL > 2047 are illegal (elaboration assertion).
- Simultaneous events: on the edge where the line and frame both wrap, pixelX=0, pixelY=0, startOfFrame=1 and frameCnt increments all together.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN.
- Defined: frameCnt increments by 1 (mod 256) on every frame wrap, in the same edge that raises startOfFrame; it wraps 255→0 and resets to 0.
- Undefined: no counter logic is instantiated and frameCnt is constant 8'h00.

Test Plan (CLK_DIV=2, PIPE_DLY=1, defaults):
- Reset, then release at edge E0 → pixelX=0 for 2 clks, then 1; pixelX=639 lasts 2 clks; wraps to 0 after 1600 clks with pixelY=1.
- Release reset and count → hsyncN falls 1313 clks after E0 (656·2+1), stays low exactly 192 clks, repeats every 1600 clks.
- Run one full frame → vsyncN low for exactly 3200 clks starting at pixelY=490 (+1 clk delay); startOfFrame pulses exactly once per 840000 clks, width 1 clk.
- Check active across the frame → high 1280 clks per line on lines 0..479 only, delayed 1 clk from pixelX; zero on lines 480..524.
- Assert resetN=0 for one edge while pixelX=700, pixelY=491 (both syncs low) → next edge hsyncN=1, vsyncN=1, active=0, counters 0, no startOfFrame.
- With VGA_FRAME_COUNTER_EN, run 257 frames → frameCnt reads 1 after frame 1, 255 then 0 at wrap, 1 after frame 257. Without the macro, frameCnt stays 0.
